// File: rtl/wb_initiator_pkg.sv
// Shared types and bus widths for the Wishbone single-transfer initiator.
package wb_initiator_pkg;

    localparam int unsigned WB_ADR_W = 32;
    localparam int unsigned WB_DAT_W = 32;
    localparam int unsigned WB_SEL_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StResp
    } state_e;

    typedef enum logic [1:0] {
        StatOk,
        StatErr,
        StatTmo
    } status_e;

    function automatic logic [WB_ADR_W-1:0] word_align(input logic [WB_ADR_W-1:0] adr);
        return {adr[WB_ADR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/wb_initiator_timer.sv
// Bus-cycle timeout counter: cleared outside the bus phase, flags the last allowed stb cycle.
module wb_initiator_timer #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] LastVal = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (TIMEOUT != 0)) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // TIMEOUT = 0 disables expiry entirely.
    assign expired_o = (TIMEOUT != 0) && (cnt_q == LastVal);

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle, one response out.
module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [WB_ADR_W-1:0] cmd_adr_i,
    input  logic [WB_SEL_W-1:0] cmd_sel_i,
    input  logic [WB_DAT_W-1:0] cmd_dat_i,
    input  logic                abort_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [WB_DAT_W-1:0] rsp_dat_o,
    output logic                rsp_err_o,
    output logic                rsp_timeout_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_SEL_W-1:0] wbm_sel_o,
    output logic [WB_ADR_W-1:0] wbm_adr_o,
    output logic [WB_DAT_W-1:0] wbm_dat_o,
    input  logic [WB_DAT_W-1:0] wbm_dat_i,
    input  logic                wbm_ack_i,
    input  logic                wbm_err_i,
    output logic                busy_o,
    output logic [CNT_W-1:0]    txn_count_o
);

    state_e                state_q, state_d;
    logic                  cyc_q, cyc_d;
    logic                  we_q, we_d;
    logic [WB_SEL_W-1:0]   sel_q, sel_d;
    logic [WB_ADR_W-1:0]   adr_q, adr_d;
    logic [WB_DAT_W-1:0]   dat_q, dat_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [WB_DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
    status_e               rsp_stat_q, rsp_stat_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic term;
    logic tmr_clr, tmr_en, tmr_expired;

    wb_initiator_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk_i    (wb_clk_i),
        .rst_ni   (wb_rst_n_i),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expired_o(tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_stat_d  = rsp_stat_q;
        cnt_d       = cnt_q;
        term        = 1'b0;

        case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    state_d = StBus;
                    cyc_d   = 1'b1;
                    we_d    = cmd_we_i;
                    sel_d   = cmd_sel_i;
                    adr_d   = word_align(cmd_adr_i);
                    dat_d   = cmd_dat_i;
                end
            end
            StBus: begin
                // Termination priority: err > ack > abort > timeout.
                if (wbm_err_i) begin
                    term       = 1'b1;
                    rsp_stat_d = StatErr;
                    rsp_dat_d  = '0;
                end else if (wbm_ack_i) begin
                    term       = 1'b1;
                    rsp_stat_d = StatOk;
                    rsp_dat_d  = we_q ? '0 : wbm_dat_i;
                end else if (abort_i) begin
                    term       = 1'b1;
                    rsp_stat_d = StatErr;
                    rsp_dat_d  = '0;
                end else if (tmr_expired) begin
                    term       = 1'b1;
                    rsp_stat_d = StatTmo;
                    rsp_dat_d  = '0;
                end
                if (term) begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    sel_d       = '0;
                    adr_d       = '0;
                    dat_d       = '0;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                    rsp_dat_d   = '0;
                    rsp_stat_d  = StatOk;
                    cnt_d       = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign tmr_clr = (state_q != StBus);
    assign tmr_en  = (state_q == StBus) && !term;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= StIdle;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_stat_q  <= StatOk;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_stat_q  <= rsp_stat_d;
            cnt_q       <= cnt_d;
        end
    end

    // Gated by reset so the port reads 0 while reset is held.
    assign cmd_ready_o   = (state_q == StIdle) && wb_rst_n_i;
    assign busy_o        = (state_q != StIdle);
    assign wbm_cyc_o     = cyc_q;
    assign wbm_stb_o     = cyc_q;
    assign wbm_we_o      = we_q;
    assign wbm_sel_o     = sel_q;
    assign wbm_adr_o     = adr_q;
    assign wbm_dat_o     = dat_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_dat_o     = rsp_dat_q;
    assign rsp_err_o     = (rsp_stat_q == StatErr);
    assign rsp_timeout_o = (rsp_stat_q == StatTmo);
    assign txn_count_o   = cnt_q;

endmodule
